// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: strips an H-byte header from each AXI-Stream packet onto a side
// channel and realigns the payload to the MSB lane. Define STRIP_HDR_ERR_EN to add err_runt.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic [BYTE_CNT_WD:0]    hdr_bytes,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
`ifdef STRIP_HDR_ERR_EN
  ,
  output logic                    err_runt
`endif
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [CW-1:0] FULL = CW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {HDR, BODY, FLUSH} state_e;

  function automatic logic [CW-1:0] popCount(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] cntToKeep(input logic [CW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (i < int'(cnt));
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] keepToMask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_e                  state_q, state_d;
  logic [CW-1:0]           hSel_q, hSel_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [CW-1:0]           resCnt_q, resCnt_d;
  logic                    hdrValid_q, hdrValid_d;
  logic [DATA_WD-1:0]      hdrData_q, hdrData_d;
  logic [DATA_BYTE_WD-1:0] hdrKeep_q, hdrKeep_d;
  logic                    outValid_q, outValid_d;
  logic [DATA_WD-1:0]      outData_q, outData_d;
  logic [DATA_BYTE_WD-1:0] outKeep_q, outKeep_d;
  logic                    outLast_q, outLast_d;

  logic [CW-1:0]           hEff, kCnt, hdrRem, bodyRem, bodyTake;
  logic [CW+2:0]           shH, shSel, shRes;
  logic [DATA_BYTE_WD-1:0] hdrKeepNew, bodyKeep, resKeep, hdrRemKeep;
  logic                    isRunt, hdrFree, outFree;

`ifdef STRIP_HDR_ERR_EN
  // An illegal header length is treated as a full-beat header.
  logic hIllegal, errRunt_q, errRunt_d;
  assign hIllegal = (hdr_bytes == '0) || (hdr_bytes > FULL);
  assign hEff     = hIllegal ? FULL : hdr_bytes;
`else
  assign hEff     = hdr_bytes;
`endif

  assign kCnt       = popCount(keep_in);
  assign isRunt     = kCnt < hEff;
  assign hdrRem     = kCnt - hEff;
  assign bodyRem    = kCnt - hSel_q;
  assign bodyTake   = (kCnt <= hSel_q) ? kCnt : hSel_q;
  assign shH        = {hEff, 3'b000};
  assign shSel      = {hSel_q, 3'b000};
  assign shRes      = {resCnt_q, 3'b000};
  assign hdrKeepNew = keep_in & cntToKeep(hEff);
  assign bodyKeep   = cntToKeep(resCnt_q + bodyTake);
  assign resKeep    = cntToKeep(resCnt_q);
  assign hdrRemKeep = cntToKeep(hdrRem);
  assign hdrFree    = !hdrValid_q || ready_header;
  assign outFree    = !outValid_q || ready_out;

  // A runt first beat selects H=DATA_BYTE_WD so the rest of the packet passes through untouched.
  always_comb begin
    state_d    = state_q;
    hSel_d     = hSel_q;
    res_d      = res_q;
    resCnt_d   = resCnt_q;
    hdrValid_d = hdrValid_q && !ready_header;
    hdrData_d  = hdrData_q;
    hdrKeep_d  = hdrKeep_q;
    outValid_d = outValid_q && !ready_out;
    outData_d  = outData_q;
    outKeep_d  = outKeep_q;
    outLast_d  = outLast_q;
    ready_in   = 1'b0;
    unique case (state_q)
      HDR: begin
        ready_in = hdrFree && outFree;
        if (valid_in && ready_in) begin
          hdrValid_d = 1'b1;
          hdrKeep_d  = hdrKeepNew;
          hdrData_d  = data_in & keepToMask(hdrKeepNew);
          hSel_d     = isRunt ? FULL : hEff;
          res_d      = isRunt ? '0 : (data_in << shH);
          resCnt_d   = isRunt ? '0 : hdrRem;
          if (!last_in) begin
            state_d = BODY;
          end else begin
            resCnt_d = '0;
            if (!isRunt && hdrRem != '0) begin
              outValid_d = 1'b1;
              outData_d  = (data_in << shH) & keepToMask(hdrRemKeep);
              outKeep_d  = hdrRemKeep;
              outLast_d  = 1'b1;
            end
          end
        end
      end
      BODY: begin
        ready_in = outFree;
        if (valid_in && ready_in) begin
          outValid_d = 1'b1;
          outData_d  = (res_q | (data_in >> shRes)) & keepToMask(bodyKeep);
          outKeep_d  = bodyKeep;
          outLast_d  = 1'b0;
          res_d      = data_in << shSel;
          resCnt_d   = FULL - hSel_q;
          if (last_in) begin
            if (kCnt <= hSel_q) begin
              outLast_d = 1'b1;
              resCnt_d  = '0;
              state_d   = HDR;
            end else begin
              resCnt_d = bodyRem;
              state_d  = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (outFree) begin
          outValid_d = 1'b1;
          outData_d  = res_q & keepToMask(resKeep);
          outKeep_d  = resKeep;
          outLast_d  = 1'b1;
          resCnt_d   = '0;
          state_d    = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HDR;
      hSel_q     <= '0;
      res_q      <= '0;
      resCnt_q   <= '0;
      hdrValid_q <= 1'b0;
      hdrData_q  <= '0;
      hdrKeep_q  <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outKeep_q  <= '0;
      outLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hSel_q     <= hSel_d;
      res_q      <= res_d;
      resCnt_q   <= resCnt_d;
      hdrValid_q <= hdrValid_d;
      hdrData_q  <= hdrData_d;
      hdrKeep_q  <= hdrKeep_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outKeep_q  <= outKeep_d;
      outLast_q  <= outLast_d;
    end
  end

`ifdef STRIP_HDR_ERR_EN
  assign errRunt_d = (state_q == HDR) && valid_in && ready_in && (isRunt || hIllegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errRunt_q <= 1'b0;
    else        errRunt_q <= errRunt_d;
  end

  assign err_runt = errRunt_q;
`endif

  assign valid_header = hdrValid_q;
  assign data_header  = hdrData_q;
  assign keep_header  = hdrKeep_q;
  assign valid_out    = outValid_q;
  assign data_out     = outData_q;
  assign keep_out     = outKeep_q;
  assign last_out     = outLast_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Testbench for axi_stream_strip_header: directed cases plus a randomized byte-level
// scoreboard. Build with STRIP_HDR_ERR_EN to also exercise err_runt.
module tb_axi_stream_strip_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic [2:0]  hdr_bytes;
  logic        valid_header;
  logic [31:0] data_header;
  logic [3:0]  keep_header;
  logic        ready_header;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
`ifdef STRIP_HDR_ERR_EN
  logic        err_runt;
`endif

  always #5 clk = ~clk;

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in), .hdr_bytes(hdr_bytes),
    .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
    .ready_header(ready_header),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
`ifdef STRIP_HDR_ERR_EN
    , .err_runt(err_runt)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t expHdr[$];
  beat_t expOut[$];
  int    total = 0;
  int    bad = 0;
  bit    stallEn = 1'b0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] maskOf(input int n);
    logic [3:0] m;
    for (int j = 0; j < 4; j++) m[3-j] = (j < n);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (stallEn) begin
      ready_out    = ($urandom_range(0, 99) < 70);
      ready_header = ($urandom_range(0, 99) < 70);
    end
  endtask

  // Holds one input beat until the DUT accepts it; returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic l,
                               input logic [2:0] h);
    int  waitCnt;
    bit  done;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l; hdr_bytes = h;
    done = 1'b0;
    waitCnt = 0;
    while (!done && waitCnt < 500) begin
      #1;
      done = ready_in;
      tick();
      waitCnt++;
    end
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    if (!done) checkVal("in_accept_timeout", 0, 1);
  endtask

  task automatic pushExp(input bit isHdr, input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t e;
    e.d = d; e.k = k; e.l = l;
    if (isHdr) expHdr.push_back(e);
    else       expOut.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((expHdr.size() != 0 || expOut.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    checkVal("drain_hdr_left", expHdr.size(), 0);
    checkVal("drain_out_left", expOut.size(), 0);
  endtask

  // Reference model: header = first min(k0,H) bytes, payload = every later byte repacked.
  task automatic sendRandomPacket();
    logic [7:0]  bytesQ[$];
    logic [31:0] bd[4];
    int          bk[4];
    int          h, nBeats, hn, idx, cnt, n;
    beat_t       e;
    logic [7:0]  b;
    h      = $urandom_range(1, 4);
    nBeats = $urandom_range(1, 4);
    for (int i = 0; i < nBeats; i++) begin
      bk[i] = (i == nBeats - 1) ? $urandom_range(1, 4) : 4;
      bd[i] = '0;
      for (int j = 0; j < bk[i]; j++) begin
        b = 8'($urandom);
        bd[i][8*(3-j) +: 8] = b;
        bytesQ.push_back(b);
      end
    end
    hn = (bk[0] < h) ? bk[0] : h;
    e.d = '0;
    for (int j = 0; j < hn; j++) e.d[8*(3-j) +: 8] = bytesQ[j];
    e.k = maskOf(hn); e.l = 1'b0;
    expHdr.push_back(e);
    n = bytesQ.size();
    idx = hn;
    while (idx < n) begin
      e.d = '0;
      cnt = 0;
      for (int j = 0; j < 4 && idx < n; j++) begin
        e.d[8*(3-j) +: 8] = bytesQ[idx];
        idx++;
        cnt++;
      end
      e.k = maskOf(cnt); e.l = (idx == n);
      expOut.push_back(e);
    end
    for (int i = 0; i < nBeats; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      applyStimulus(bd[i], maskOf(bk[i]), (i == nBeats - 1),
                    (i == 0) ? 3'(h) : 3'($urandom_range(0, 7)));
    end
  endtask

  // Output monitor: pops expectations on each handshake and checks that stalled beats hold.
  beat_t eh, eo, prevHdr, prevOut;
  bit    pendHdr = 1'b0, pendOut = 1'b0;

  task automatic checkOutput();
    if (pendHdr) begin
      checkVal("hdr_hold_valid", valid_header, 1);
      checkVal("hdr_hold_data", {data_header, keep_header}, {prevHdr.d, prevHdr.k});
    end
    pendHdr = 1'b0;
    if (valid_header) begin
      if (ready_header) begin
        if (expHdr.size() == 0) checkVal("hdr_unexpected", 1, 0);
        else begin
          eh = expHdr.pop_front();
          checkVal("hdr_data", data_header, eh.d);
          checkVal("hdr_keep", keep_header, eh.k);
        end
      end else begin
        pendHdr = 1'b1; prevHdr.d = data_header; prevHdr.k = keep_header;
      end
    end
    if (pendOut) begin
      checkVal("out_hold_valid", valid_out, 1);
      checkVal("out_hold_data", {data_out, keep_out, last_out}, {prevOut.d, prevOut.k, prevOut.l});
    end
    pendOut = 1'b0;
    if (valid_out) begin
      if (ready_out) begin
        if (expOut.size() == 0) checkVal("out_unexpected", 1, 0);
        else begin
          eo = expOut.pop_front();
          checkVal("out_data", data_out, eo.d);
          checkVal("out_keep", keep_out, eo.k);
          checkVal("out_last", last_out, eo.l);
        end
      end else begin
        pendOut = 1'b1; prevOut.d = data_out; prevOut.k = keep_out; prevOut.l = last_out;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pendHdr = 1'b0;
        pendOut = 1'b0;
      end else begin
        checkOutput();
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    hdr_bytes = 3'd2; ready_header = 1'b1; ready_out = 1'b1;
    repeat (3) tick();
    checkVal("rst_valid_header", valid_header, 0);
    checkVal("rst_valid_out", valid_out, 0);
    checkVal("rst_last_out", last_out, 0);
    checkVal("rst_data", {data_header, data_out}, 64'h0);
    checkVal("rst_keep", {keep_header, keep_out}, 8'h0);
    checkVal("rst_ready_in", ready_in, 1);
    rst_n = 1'b1;
    tick();

    $display("[TB] test 1: three-beat packet, H=2");
    pushExp(1, 32'h00110000, 4'b1100, 0);
    pushExp(0, 32'h22334455, 4'b1111, 0);
    pushExp(0, 32'h66778899, 4'b1111, 1);
    applyStimulus(32'h00112233, 4'b1111, 0, 3'd2);
    applyStimulus(32'h44556677, 4'b1111, 0, 3'd2);
    applyStimulus(32'h88990000, 4'b1100, 1, 3'd2);
    drain();

    $display("[TB] test 2: last beat overflows into a flush beat");
    pushExp(1, 32'h00110000, 4'b1100, 0);
    pushExp(0, 32'h22334455, 4'b1111, 0);
    pushExp(0, 32'h66778899, 4'b1111, 0);
    pushExp(0, 32'hAA000000, 4'b1000, 1);
    applyStimulus(32'h00112233, 4'b1111, 0, 3'd2);
    applyStimulus(32'h44556677, 4'b1111, 0, 3'd2);
    applyStimulus(32'h8899AA00, 4'b1110, 1, 3'd2);
    checkVal("flush_ready_in", ready_in, 0);
    drain();

    $display("[TB] test 3: single-beat packets");
    pushExp(1, 32'hDEAD0000, 4'b1100, 0);
    pushExp(0, 32'hBEEF0000, 4'b1100, 1);
    applyStimulus(32'hDEADBEEF, 4'b1111, 1, 3'd2);
    drain();
    pushExp(1, 32'hDEADBEEF, 4'b1111, 0);
    applyStimulus(32'hDEADBEEF, 4'b1111, 1, 3'd4);
    drain();

    $display("[TB] test 4: H=4 pass-through");
    pushExp(1, 32'h01020304, 4'b1111, 0);
    pushExp(0, 32'hA1A2A3A4, 4'b1111, 0);
    pushExp(0, 32'hB1B20000, 4'b1100, 1);
    applyStimulus(32'h01020304, 4'b1111, 0, 3'd4);
    applyStimulus(32'hA1A2A3A4, 4'b1111, 0, 3'd4);
    applyStimulus(32'hB1B20000, 4'b1100, 1, 3'd4);
    drain();

    $display("[TB] test 5: runt first beat");
    pushExp(1, 32'hCAFE0000, 4'b1100, 0);
    applyStimulus(32'hCAFE0000, 4'b1100, 1, 3'd3);
`ifdef STRIP_HDR_ERR_EN
    checkVal("err_runt_pulse", err_runt, 1);
    tick();
    checkVal("err_runt_clear", err_runt, 0);
`endif
    drain();

`ifdef STRIP_HDR_ERR_EN
    $display("[TB] test 5b: illegal H forced to full beat");
    pushExp(1, 32'h11223344, 4'b1111, 0);
    applyStimulus(32'h11223344, 4'b1111, 1, 3'd0);
    checkVal("err_illegal_pulse", err_runt, 1);
    tick();
    checkVal("err_illegal_clear", err_runt, 0);
    drain();
`endif

    $display("[TB] test 6: reset in BODY");
    ready_out = 1'b0; ready_header = 1'b0;
    applyStimulus(32'h00112233, 4'b1111, 0, 3'd2);
    applyStimulus(32'h44556677, 4'b1111, 0, 3'd2);
    checkVal("pre_rst_valid_header", valid_header, 1);
    checkVal("pre_rst_valid_out", valid_out, 1);
    #1 rst_n = 1'b0;
    #1;
    checkVal("async_rst_valid_header", valid_header, 0);
    checkVal("async_rst_valid_out", valid_out, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    ready_out = 1'b1; ready_header = 1'b1;
    tick();
    pushExp(1, 32'hDEAD0000, 4'b1100, 0);
    pushExp(0, 32'hBEEF0000, 4'b1100, 1);
    applyStimulus(32'hDEADBEEF, 4'b1111, 1, 3'd2);
    drain();

    $display("[TB] test 7: 200 random packets with sink stalls");
    stallEn = 1'b1;
    for (int p = 0; p < 200; p++) sendRandomPacket();
    drain();
    stallEn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
